// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam logic [31:0] HALT_OP = 32'h0000_0000;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter with sync clear that holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run FSM plus load-use/branch hazard control and performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_uses_rs2_i,
  input  logic              id_branch_i,
  input  logic              id_cond_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  output logic              pc_we_o,
  output logic              pc_sel_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              stall_o,
  output logic              taken_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_t state, nxt;
  logic [DW-1:0] dcnt;
  logic hazard, budget_hit;
  assign hazard = ex_memread_i && ex_rd_addr_i != '0 &&
                  (ex_rd_addr_i == id_rs1_addr_i || (id_uses_rs2_i && ex_rd_addr_i == id_rs2_addr_i));
  assign budget_hit = MAX_CYCLES != 0 && cycle_cnt_o == CNT_W'(MAX_CYCLES - 1);
  assign state_o = state;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
      dcnt   <= '0;
    end else begin
      state  <= nxt;
      done_o <= nxt == DONE;
      if (state == RUN && nxt == DRAIN) dcnt <= DW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && dcnt != '0) dcnt <= dcnt - 1'b1;
    end
  // Outside RUN the front end is frozen and ID/EX receives bubbles.
  always_comb begin
    nxt           = state;
    pc_we_o       = 1'b0;
    pc_sel_o      = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    stall_o       = 1'b0;
    taken_o       = 1'b0;
    case (state)
      IDLE:  nxt = start_i ? RUN : IDLE;
      RUN: begin
        if (hazard) stall_o = 1'b1;
        else if (halt_i) ifid_flush_o = 1'b1;
        else begin
          taken_o       = id_branch_i && id_cond_i;
          pc_sel_o      = taken_o;
          ifid_flush_o  = taken_o;
          pc_we_o       = 1'b1;
          ifid_we_o     = 1'b1;
          idex_bubble_o = 1'b0;
        end
        nxt = (halt_i && !hazard) || budget_hit ? DRAIN : start_i ? RUN : IDLE;
      end
      DRAIN: begin
        ifid_flush_o = 1'b1;
        nxt          = dcnt == '0 ? DONE : DRAIN;
      end
      default: nxt = DONE;
    endcase
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(stall_o), .clr(1'b0), .q(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(taken_o), .clr(1'b0), .q(flush_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(state == RUN || state == DRAIN), .clr(1'b0), .q(cycle_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of hazard control, run FSM and counters on two configurations
module tb_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, halt, uses_rs2, branch, cond, memread;
  logic [4:0] rs1, rs2, rd;
  logic pc_we, pc_sel, ifid_we, ifid_flush, bubble, stall, taken, done;
  logic [1:0] state;
  logic [31:0] stall_cnt, flush_cnt, cycle_cnt;
  logic b_rst_n, b_start;
  logic b_pc_we, b_pc_sel, b_ifid_we, b_ifid_flush, b_bubble, b_stall, b_taken, b_done;
  logic [1:0] b_state;
  logic [2:0] b_stall_cnt, b_flush_cnt, b_cycle_cnt;
  int checks = 0, failures = 0;

  pipe_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .halt_i(halt),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs2_i(uses_rs2),
    .id_branch_i(branch), .id_cond_i(cond), .ex_memread_i(memread), .ex_rd_addr_i(rd),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(bubble), .stall_o(stall), .taken_o(taken), .state_o(state), .done_o(done),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .cycle_cnt_o(cycle_cnt)
  );

  pipe_ctrl #(.CNT_W(3), .MAX_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .start_i(b_start), .halt_i(halt),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs2_i(uses_rs2),
    .id_branch_i(branch), .id_cond_i(cond), .ex_memread_i(memread), .ex_rd_addr_i(rd),
    .pc_we_o(b_pc_we), .pc_sel_o(b_pc_sel), .ifid_we_o(b_ifid_we), .ifid_flush_o(b_ifid_flush),
    .idex_bubble_o(b_bubble), .stall_o(b_stall), .taken_o(b_taken), .state_o(b_state), .done_o(b_done),
    .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt), .cycle_cnt_o(b_cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id;
    halt = 0; rs1 = 0; rs2 = 0; uses_rs2 = 0; branch = 0; cond = 0; memread = 0; rd = 0;
  endtask

  initial begin
    rst_n = 0; b_rst_n = 0; start = 0; b_start = 0;
    clear_id();
    repeat (5) tick();
    chk("rst_state", state, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_ifid_we", ifid_we, 0);
    chk("rst_bubble", bubble, 1);
    chk("rst_done", done, 0);
    chk("rst_cnts", stall_cnt | flush_cnt | cycle_cnt, 0);
    rst_n = 1;
    tick();
    chk("idle_hold", state, 0);
    start = 1;
    tick();
    chk("run_entry", state, 1);
    chk("run_pc_we", pc_we, 1);
    chk("run_ifid_we", ifid_we, 1);
    chk("run_bubble", bubble, 0);
    memread = 1; rd = 5; rs1 = 5; #1;
    chk("lu_stall", stall, 1);
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_bubble", bubble, 1);
    tick();
    memread = 0; #1;
    chk("lu_stall_gone", stall, 0);
    chk("lu_pc_we_back", pc_we, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    memread = 1; rd = 7; rs1 = 1; rs2 = 7; uses_rs2 = 1; #1;
    chk("rs2_stall", stall, 1);
    uses_rs2 = 0; #1;
    chk("rs2_unused", stall, 0);
    rd = 0; rs1 = 0; #1;
    chk("x0_no_stall", stall, 0);
    chk("x0_pc_we", pc_we, 1);
    tick();
    clear_id();
    branch = 1; cond = 0; #1;
    chk("br_not_taken", taken, 0);
    cond = 1; #1;
    chk("br_taken", taken, 1);
    chk("br_pc_sel", pc_sel, 1);
    chk("br_flush", ifid_flush, 1);
    chk("br_pc_we", pc_we, 1);
    tick();
    clear_id(); #1;
    chk("br_one_cycle", taken, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    branch = 1; cond = 1; memread = 1; rd = 3; rs1 = 3; #1;
    chk("brhz_stall", stall, 1);
    chk("brhz_no_taken", taken, 0);
    tick();
    memread = 0; #1;
    chk("brhz_retry_taken", taken, 1);
    chk("brhz_retry_stall", stall, 0);
    tick();
    clear_id(); #1;
    chk("brhz_stall_cnt", stall_cnt, 2);
    chk("brhz_flush_cnt", flush_cnt, 2);
    halt = 1; memread = 1; rd = 4; rs1 = 4; #1;
    chk("halt_hz_stall", stall, 1);
    tick();
    chk("halt_hz_stay_run", state, 1);
    memread = 0; #1;
    chk("halt_pc_we", pc_we, 0);
    chk("halt_flush", ifid_flush, 1);
    tick();
    halt = 0;
    chk("drain_entry", state, 2);
    chk("drain_cycle_cnt", cycle_cnt, 7);
    chk("drain_pc_we", pc_we, 0);
    chk("drain_flush", ifid_flush, 1);
    chk("drain_bubble", bubble, 1);
    start = 0;
    tick();
    chk("drain_2", state, 2);
    tick();
    chk("drain_3", state, 2);
    tick();
    chk("done_state", state, 3);
    chk("done_flag", done, 1);
    chk("done_cycle_cnt", cycle_cnt, 10);
    chk("done_stall_cnt", stall_cnt, 3);
    chk("done_flush_cnt", flush_cnt, 2);
    memread = 1; rd = 6; rs1 = 6; branch = 1; cond = 1;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      tick();
    end
    chk("frozen_state", state, 3);
    chk("frozen_done", done, 1);
    chk("frozen_stall", stall, 0);
    chk("frozen_pc_we", pc_we, 0);
    chk("frozen_cnts", {stall_cnt[7:0], flush_cnt[7:0], cycle_cnt[15:0]}, {8'd3, 8'd2, 16'd10});
    clear_id();
    b_rst_n = 1; b_start = 1;
    tick();
    chk("b_run", b_state, 1);
    b_start = 0;
    tick();
    chk("b_stop_idle", b_state, 0);
    chk("b_stop_cycle", b_cycle_cnt, 1);
    b_start = 1;
    tick();
    chk("b_rerun", b_state, 1);
    chk("b_rerun_cycle", b_cycle_cnt, 1);
    repeat (6) tick();
    chk("b_pre_budget_state", b_state, 1);
    chk("b_pre_budget_cycle", b_cycle_cnt, 7);
    tick();
    chk("b_budget_drain", b_state, 2);
    chk("b_sat_cycle", b_cycle_cnt, 7);
    tick();
    chk("b_no_wrap", b_cycle_cnt, 7);
    chk("b_still_drain", b_state, 2);
    #2 b_rst_n = 0;
    #1;
    chk("b_async_state", b_state, 0);
    chk("b_async_cycle", b_cycle_cnt, 0);
    chk("b_async_pc_we", b_pc_we, 0);
    chk("b_async_bubble", b_bubble, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
